// File: rtl/fifo_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fifo_stream_pkg
// Purpose : Shared types and constants for the FIFO stream reader slice.
// Rev     : 1.0  initial release
// ============================================================================
package fifo_stream_pkg;

    // Default data width of the upstream FIFO
    localparam int DATA_W    = 8;

    // Output buffer depth; the read-credit logic keeps occupancy plus the
    // outstanding read within this bound
    localparam int BUF_DEPTH = 2;

    typedef logic [DATA_W-1:0] data_t;

    // Output buffer occupancy
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

endpackage : fifo_stream_pkg
`default_nettype wire

// File: rtl/stream_skid_buf.sv
`default_nettype none
// ============================================================================
// Module  : stream_skid_buf
// Purpose : Two-entry in-order buffer. The head register drives the stream
//           output directly; the tail absorbs the read that was already in
//           flight when the consumer stalled.
// Rev     : 1.0  initial release
// ============================================================================
module stream_skid_buf
    import fifo_stream_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [1:0]       o_occ,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_head
);

    occ_e             r_occ;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;

    // Occupancy and storage update; simultaneous write and pop keep occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ  <= EMPTY;
            r_head <= '0;
            r_tail <= '0;
        end else if (i_flush) begin
            r_occ <= EMPTY;
        end else begin
            case (r_occ)
                EMPTY: begin
                    if (i_wr) begin
                        r_head <= i_wr_data;
                        r_occ  <= ONE;
                    end
                end
                ONE: begin
                    if (i_wr && i_pop) begin
                        r_head <= i_wr_data;
                    end else if (i_wr) begin
                        r_tail <= i_wr_data;
                        r_occ  <= TWO;
                    end else if (i_pop) begin
                        r_occ <= EMPTY;
                    end
                end
                TWO: begin
                    // A write into a full buffer cannot coincide without a pop
                    if (i_pop) begin
                        r_head <= r_tail;
                        if (i_wr) begin
                            r_tail <= i_wr_data;
                        end else begin
                            r_occ <= ONE;
                        end
                    end
                end
                default: begin
                    r_occ <= EMPTY;
                end
            endcase
        end
    end

    assign o_occ   = r_occ;
    assign o_valid = (r_occ != EMPTY);
    assign o_head  = r_head;

endmodule : stream_skid_buf
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module  : fifo_stream_reader
// Purpose : Drains an 8-bit FIFO with one-cycle read latency onto a
//           valid/ready stream, frames it into fixed-length packets and
//           counts completed packets.
// Rev     : 1.0  initial release
// ============================================================================
module fifo_stream_reader
    import fifo_stream_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int PKT_LEN = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_fifo_empty,
    input  logic [WIDTH-1:0] i_fifo_data,
    output logic             o_fifo_rd_en,
    input  logic             i_flush,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_data,
    output logic             o_out_last,
    output logic [CNT_W-1:0] o_pkt_count
);

    // Beat counter needs at least one bit even for single-beat packets
    localparam int              BC_W        = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BC_W-1:0] C_LAST_BEAT = BC_W'(PKT_LEN - 1);

    logic             r_inflight;
    logic [BC_W-1:0]  r_beat_cnt;
    logic [CNT_W-1:0] r_pkt_count;

    logic [1:0]       w_occ;
    logic             w_valid;
    logic [WIDTH-1:0] w_head;
    logic             w_pop;
    logic             w_last;
    logic             w_rd_en;
    logic [2:0]       w_pending;
    logic [2:0]       w_level;

    assign w_pop     = w_valid & i_out_ready;
    // Entries held or owed to the buffer before this cycle's pop
    assign w_pending = {1'b0, w_occ} + {2'b0, r_inflight};
    // Occupancy after this edge if no new read were issued
    assign w_level   = w_pending - {2'b0, w_pop};
    // A new read is only issued when its data is guaranteed a slot; rst_n
    // gates the request so nothing is read while the block is held in reset
    assign w_rd_en   = rst_n & ~i_fifo_empty & ~i_flush & (w_level <= 3'd1);
    assign w_last    = w_valid & (r_beat_cnt == C_LAST_BEAT);

    stream_skid_buf #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr      (r_inflight & ~i_flush),
        .i_wr_data (i_fifo_data),
        .i_pop     (w_pop & ~i_flush),
        .i_flush   (i_flush),
        .o_occ     (w_occ),
        .o_valid   (w_valid),
        .o_head    (w_head)
    );

    // Track the read issued last cycle; its data lands in the buffer this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
        end
    end

    // Packet framing and completed-packet counter; a pop during flush is void
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt  <= '0;
            r_pkt_count <= '0;
        end else if (i_flush) begin
            r_beat_cnt <= '0;
        end else if (w_pop) begin
            if (w_last) begin
                r_beat_cnt  <= '0;
                r_pkt_count <= r_pkt_count + CNT_W'(1);
            end else begin
                r_beat_cnt <= r_beat_cnt + BC_W'(1);
            end
        end
    end

    assign o_fifo_rd_en = w_rd_en;
    assign o_out_valid  = w_valid;
    assign o_out_data   = w_head;
    assign o_out_last   = w_last;
    assign o_pkt_count  = r_pkt_count;

    // Buffer plus outstanding read never exceeds the buffer depth
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        w_pending <= 3'(BUF_DEPTH));

endmodule : fifo_stream_reader
`default_nettype wire
